instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Sequential RV32I instruction encoder: the reverse direction of the main control decoder.
- Accepts instruction-class plus field requests over a valid/ready handshake and packs them into 32-bit instruction words.
- Range-checks immediates, buffers results in a 2-entry FIFO and tags each word with a sequential instruction-memory byte address.
- Used by the boot/program loader and by the bench to generate instruction streams for the core.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address tagged on the first emitted word.
- DEPTH, 2, output FIFO entries; fixed at 2, other values unsupported.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid and in_ready are both high on a rising edge
- kind  input  3  0=LOAD(0000011) 1=STORE(0100011) 2=RTYPE(0110011) 3=BRANCH(1100011) 4=ITYPE(0010011) 5=JAL(1101111); 6,7 illegal
- rd  input  5  destination register
- rs1  input  5  source register 1
- rs2  input  5  source register 2
- funct3  input  3  funct3 field
- funct7  input  7  funct7 field, used only by RTYPE
- imm  input  32  signed byte-offset immediate
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer pops head when out_valid and out_ready are both high
- out_instr  output  32  encoded instruction at FIFO head
- out_addr  output  32  byte address of the head word
- err  output  1  one-cycle pulse, asserted the cycle after an illegal request is accepted
- count  output  16  number of words pushed since reset; wraps at 16'hFFFF->0

Behaviour:
- Reset: FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, count=0, next-address register=BASE_ADDR. Reset mid-operation discards FIFO contents.
- in_ready = (occupancy < 2). It is registered state only; it does not depend on out_ready in the same cycle, so there is no pass-through when full.
- Encoding (bit ranges are in the output word):
  - LOAD/ITYPE (I-type): imm[11:0]->[31:20], rs1->[19:15], funct3->[14:12], rd->[11:7].
  - STORE (S-type): imm[11:5]->[31:25], rs2->[24:20], rs1, funct3, imm[4:0]->[11:7].
  - RTYPE: funct7->[31:25], rs2, rs1, funct3, rd.
  - BRANCH (B-type): imm[12]->31, imm[10:5]->[30:25], rs2, rs1, funct3, imm[4:1]->[11:8], imm[11]->7.
  - JAL (J-type): imm[20]->31, imm[10:1]->[30:21], imm[11]->20, imm[19:12]->[19:12], rd.
  - Opcode always occupies [6:0].
- Legality checks:
  - I/S: imm must lie in -2048..2047.
  - B: imm in -4096..4094 and imm[0]=0.
  - J: imm in -1048576..1048574 and imm[0]=0.
  - kind 6 or 7 is illegal.
- Illegal request: still consumed (handshake completes), nothing pushed, err=1 for exactly the next cycle, count and next-address unchanged.
- Legal request: encoded and pushed the same edge. Entry is tagged with the next-address value, then next-address += 4 (wraps mod 2^32) and count += 1.
- Latency: word accepted at edge N is visible on out_* after edge N if the FIFO was empty. Otherwise it appears after preceding entries drain, in order.
- Simultaneous push and pop (occupancy 1): occupancy stays 1, the new word becomes head after the edge.
- Pop from empty FIFO is ignored. out_instr/out_addr hold their last value when out_valid=0.

Test Plan:
- LOAD rd=5 rs1=2 funct3=010 imm=8, out_ready=1 -> out_instr=0x00812283, out_addr=0x0, out_valid the cycle after accept, count=1.
- RTYPE rd=3 rs1=1 rs2=2 funct3=0 funct7=0, then STORE rs1=2 rs2=6 funct3=010 imm=12 -> 0x002081B3 @0x0 then 0x00612623 @0x4.
- BRANCH rs1=0 rs2=0 funct3=0 imm=-4 -> 0xFE000EE3; JAL rd=1 imm=8 -> 0x008000EF; addresses increase by 4.
- JAL imm=3, BRANCH imm=4096, kind=6 -> each is accepted, err pulses 1 cycle each, no out_valid, count and address unchanged; a following legal LOAD gets the next sequential address.
- out_ready=0, three back-to-back requests -> in_ready=0 after the second; third is held and not lost; raising out_ready drains words in order with addresses 0x0, 0x4, 0x8.
- Reset asserted with 2 entries queued -> out_valid=0, count=0, out_addr=BASE_ADDR next cycle; the next request is tagged BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs class/field requests into words,
// range-checks immediates and queues results in a 2-entry FIFO.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] count
);

  localparam logic [1:0] DEPTH_L = DEPTH[1:0];

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic        head_v;
  logic        tail_v;
  logic [31:0] head_instr;
  logic [31:0] head_addr;
  logic [31:0] tail_instr;
  logic [31:0] tail_addr;
  logic [31:0] next_addr;
  logic [15:0] cnt;
  logic        err_q;

  logic [1:0]  occ;
  logic        k_ld;
  logic        k_st;
  logic        k_rt;
  logic        k_br;
  logic        k_it;
  logic        k_jl;
  logic        i_ok;
  logic        b_ok;
  logic        j_ok;
  logic [31:0] enc;
  logic        legal;
  logic        acc;
  logic        push;
  logic        pop;

  assign occ      = {1'b0, head_v} + {1'b0, tail_v};
  assign in_ready = occ < DEPTH_L;

  assign k_ld = kind == 3'd0;
  assign k_st = kind == 3'd1;
  assign k_rt = kind == 3'd2;
  assign k_br = kind == 3'd3;
  assign k_it = kind == 3'd4;
  assign k_jl = kind == 3'd5;

  // Immediate fits when all bits above the field's sign bit replicate it
  assign i_ok = imm[31:11] == {21{imm[11]}};
  assign b_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
  assign j_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];

  // Pack the request into an instruction word and judge its legality
  always_comb begin
    enc   = 32'h0;
    legal = 1'b0;
    unique case (1'b1)
      k_ld, k_it: begin
        enc   = {imm[11:0], rs1, funct3, rd,
                 k_ld ? OP_LOAD : OP_ITYPE};
        legal = i_ok;
      end
      k_st: begin
        enc   = {imm[11:5], rs2, rs1, funct3,
                 imm[4:0], OP_STORE};
        legal = i_ok;
      end
      k_rt: begin
        enc   = {funct7, rs2, rs1, funct3, rd, OP_RTYPE};
        legal = 1'b1;
      end
      k_br: begin
        enc   = {imm[12], imm[10:5], rs2, rs1, funct3,
                 imm[4:1], imm[11], OP_BR};
        legal = b_ok;
      end
      k_jl: begin
        enc   = {imm[20], imm[10:1], imm[11], imm[19:12],
                 rd, OP_JAL};
        legal = j_ok;
      end
      default: begin
        enc   = 32'h0;
        legal = 1'b0;
      end
    endcase
  end

  assign acc  = in_valid && in_ready;
  assign push = acc && legal;
  assign pop  = head_v && out_ready;

  // Head/tail FIFO; head registers keep the last word once drained
  always_ff @(posedge clk) begin
    if (reset) begin
      head_v     <= 1'b0;
      tail_v     <= 1'b0;
      head_instr <= 32'h0;
      head_addr  <= BASE_ADDR;
      tail_instr <= 32'h0;
      tail_addr  <= BASE_ADDR;
    end else if (pop) begin
      if (tail_v) begin
        head_instr <= tail_instr;
        head_addr  <= tail_addr;
        head_v     <= 1'b1;
        tail_v     <= push;
        if (push) begin
          tail_instr <= enc;
          tail_addr  <= next_addr;
        end
      end else begin
        head_v <= push;
        if (push) begin
          head_instr <= enc;
          head_addr  <= next_addr;
        end
      end
    end else if (push) begin
      if (!head_v) begin
        head_instr <= enc;
        head_addr  <= next_addr;
        head_v     <= 1'b1;
      end else begin
        tail_instr <= enc;
        tail_addr  <= next_addr;
        tail_v     <= 1'b1;
      end
    end
  end

  // Address tag, push counter and illegal-request pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      next_addr <= BASE_ADDR;
      cnt       <= 16'h0;
      err_q     <= 1'b0;
    end else begin
      err_q <= acc && !legal;
      if (push) begin
        next_addr <= next_addr + 32'd4;
        cnt       <= cnt + 16'd1;
      end
    end
  end

  assign out_valid = head_v;
  assign out_instr = head_instr;
  assign out_addr  = head_addr;
  assign err       = err_q;
  assign count     = cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed test-plan cases plus a randomized
// run against a queue-based reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  kind;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } ent_t;

  instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .count(count)
  );

  always #5 clk = ~clk;

  // Reference encoder: field placement by shift/mask arithmetic
  function automatic logic [31:0] ref_enc(
    input logic [2:0] k, input logic [4:0] d,
    input logic [4:0] s1, input logic [4:0] s2,
    input logic [2:0] f3, input logic [6:0] f7,
    input logic [31:0] im, output bit ok);
    int v;
    logic [31:0] mid;
    logic [31:0] r;
    v   = int'($signed(im));
    mid = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12);
    r   = 32'h0;
    ok  = 1'b0;
    case (k)
      3'd0, 3'd4: begin
        ok = v >= -2048 && v <= 2047;
        r  = ((im & 32'hFFF) << 20) | (32'(s1) << 15)
           | (32'(f3) << 12) | (32'(d) << 7)
           | ((k == 3'd0) ? 32'h03 : 32'h13);
      end
      3'd1: begin
        ok = v >= -2048 && v <= 2047;
        r  = (((im >> 5) & 32'h7F) << 25) | mid
           | ((im & 32'h1F) << 7) | 32'h23;
      end
      3'd2: begin
        ok = 1'b1;
        r  = (32'(f7) << 25) | mid | (32'(d) << 7) | 32'h33;
      end
      3'd3: begin
        ok = v >= -4096 && v <= 4094 && (v % 2) == 0;
        r  = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25)
           | mid | (((im >> 1) & 32'hF) << 8)
           | (((im >> 11) & 1) << 7) | 32'h63;
      end
      3'd5: begin
        ok = v >= -1048576 && v <= 1048574 && (v % 2) == 0;
        r  = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
           | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12)
           | (32'(d) << 7) | 32'h6F;
      end
      default: begin
        ok = 1'b0;
        r  = 32'h0;
      end
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drive one request and hold it until accepted (bounded)
  task automatic req(input logic [2:0] k, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2,
                     input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] im);
    int n;
    kind = k; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: in_ready stuck at %b, need 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0 || count !== 16'd0) begin
      errors++;
      $display("FAIL reset_ctl: v=%b e=%b c=%0d need 0 0 0",
               out_valid, err, count);
    end
    checks++;
    if (out_instr !== 32'h0 || out_addr !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_data: i=%h a=%h r=%b need 0 0 1",
               out_instr, out_addr, in_ready);
    end
  endtask

  task automatic test_load();
    do_reset();
    out_ready = 1'b1;
    req(3'd0, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00812283
        || out_addr !== 32'h0 || count !== 16'd1) begin
      errors++;
      $display("FAIL load: v=%b i=%h a=%h c=%0d need 1 00812283 0 1",
               out_valid, out_instr, out_addr, count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h00812283) begin
      errors++;
      $display("FAIL load_drain: v=%b i=%h need 0 00812283",
               out_valid, out_instr);
    end
  endtask

  task automatic test_rtype_store();
    do_reset();
    out_ready = 1'b0;
    req(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    req(3'd1, 5'd0, 5'd2, 5'd6, 3'b010, 7'd0, 32'd12);
    checks++;
    if (out_instr !== 32'h002081B3 || out_addr !== 32'h0) begin
      errors++;
      $display("FAIL rtype: i=%h a=%h need 002081b3 0",
               out_instr, out_addr);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00612623
        || out_addr !== 32'h4) begin
      errors++;
      $display("FAIL store: v=%b i=%h a=%h need 1 00612623 4",
               out_valid, out_instr, out_addr);
    end
    tick();
  endtask

  task automatic test_branch_jal();
    do_reset();
    out_ready = 1'b0;
    req(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    req(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    checks++;
    if (out_instr !== 32'hFE000EE3 || out_addr !== 32'h0) begin
      errors++;
      $display("FAIL branch: i=%h a=%h need fe000ee3 0",
               out_instr, out_addr);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_instr !== 32'h008000EF || out_addr !== 32'h4
        || count !== 16'd2) begin
      errors++;
      $display("FAIL jal: i=%h a=%h c=%0d need 008000ef 4 2",
               out_instr, out_addr, count);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [2:0]  ks [3] = '{3'd5, 3'd3, 3'd6};
    logic [31:0] is [3] = '{32'd3, 32'd4096, 32'd0};
    do_reset();
    out_ready = 1'b1;
    req(3'd0, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd4);
    tick();
    for (int i = 0; i < 3; i++) begin
      req(ks[i], 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, is[i]);
      checks++;
      if (err !== 1'b1 || out_valid !== 1'b0 || count !== 16'd1) begin
        errors++;
        $display("FAIL illegal%0d: e=%b v=%b c=%0d need 1 0 1",
                 i, err, out_valid, count);
      end
      tick();
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL illegal%0d_pulse: e=%b need 0", i, err);
      end
    end
    req(3'd0, 5'd7, 5'd3, 5'd0, 3'd2, 7'd0, 32'hFFFF_F800);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 32'h4
        || out_instr !== 32'h8001A383 || count !== 16'd2) begin
      errors++;
      $display("FAIL after_illegal: v=%b i=%h a=%h c=%0d need 1 8001a383 4 2",
               out_valid, out_instr, out_addr, count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    bit ok;
    for (int i = 0; i < 3; i++)
      w[i] = ref_enc(3'd0, 5'(i + 1), 5'd4, 5'd0, 3'd2, 7'd0,
                     32'(i * 16), ok);
    do_reset();
    out_ready = 1'b0;
    kind = 3'd0; rs1 = 5'd4; rs2 = 5'd0; funct3 = 3'd2; funct7 = 7'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd = 5'(i + 1);
      imm = 32'(i * 16);
      tick();
    end
    tick();
    checks++;
    if (in_ready !== 1'b0 || count !== 16'd2 || out_instr !== w[0]
        || out_addr !== 32'h0) begin
      errors++;
      $display("FAIL full: r=%b c=%0d i=%h a=%h need 0 2 %h 0",
               in_ready, count, out_instr, out_addr, w[0]);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_instr !== w[1] || out_addr !== 32'h4 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain1: i=%h a=%h r=%b need %h 4 1",
               out_instr, out_addr, in_ready, w[1]);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_instr !== w[2] || out_addr !== 32'h8 || count !== 16'd3) begin
      errors++;
      $display("FAIL drain2: i=%h a=%h c=%0d need %h 8 3",
               out_instr, out_addr, count, w[2]);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: v=%b need 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    req(3'd4, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
    req(3'd4, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 16'd0 || out_addr !== 32'h0
        || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: v=%b c=%0d a=%h r=%b need 0 0 0 1",
               out_valid, count, out_addr, in_ready);
    end
    req(3'd4, 5'd9, 5'd1, 5'd0, 3'd0, 7'd0, 32'd3);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 32'h0 || count !== 16'd1) begin
      errors++;
      $display("FAIL post_reset: v=%b a=%h c=%0d need 1 0 1",
               out_valid, out_addr, count);
    end
  endtask

  task automatic test_random();
    ent_t q [$];
    ent_t e;
    logic [31:0] ea;
    logic [31:0] hold_i;
    logic [31:0] hold_a;
    logic [15:0] ec;
    logic [31:0] enc;
    logic        eerr;
    bit          ok;
    bit          acc;
    bit          pp;
    int          bad;
    logic [31:0] edges [12] = '{
      32'hFFFF_F800, 32'd2047, 32'd2048, 32'hFFFF_F7FF,
      32'hFFFF_F000, 32'd4094, 32'd4095, 32'd4096,
      32'hFFF0_0000, 32'h000F_FFFE, 32'h0010_0000, 32'hFFFF_EFFF};
    do_reset();
    ea = 32'h0; ec = 16'd0; eerr = 1'b0;
    hold_i = 32'h0; hold_a = 32'h0;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)
          || err !== eerr || count !== ec) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rnd_ctl@%0d: v=%b r=%b e=%b c=%0d need %b %b %b %0d",
                   c, out_valid, in_ready, err, count,
                   q.size() > 0, q.size() < 2, eerr, ec);
      end
      if (q.size() > 0) begin
        hold_i = q[0].instr;
        hold_a = q[0].addr;
      end
      checks++;
      if (out_instr !== hold_i || out_addr !== hold_a) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rnd_data@%0d: i=%h a=%h need %h %h",
                   c, out_instr, out_addr, hold_i, hold_a);
      end
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      kind   = 3'($urandom_range(0, 7));
      rd     = 5'($urandom);
      rs1    = 5'($urandom);
      rs2    = 5'($urandom);
      funct3 = 3'($urandom);
      funct7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0: imm = 32'($signed($urandom_range(0, 80)) - 40);
        1: imm = $urandom;
        default: imm = edges[$urandom_range(0, 11)];
      endcase
      enc = ref_enc(kind, rd, rs1, rs2, funct3, funct7, imm, ok);
      acc = in_valid && q.size() < 2;
      pp  = out_ready && q.size() > 0;
      tick();
      if (pp) void'(q.pop_front());
      eerr = acc && !ok;
      if (acc && ok) begin
        e.instr = enc;
        e.addr  = ea;
        q.push_back(e);
        ea = ea + 32'd4;
        ec = ec + 16'd1;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    kind = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    test_reset();
    test_load();
    test_rtype_store();
    test_branch_jal();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
